// File: rtl/tick_step_counter_pkg.sv
// Shared types and constants for the tick-driven step counter.
// Build option: TICK_STEP_COUNTER_SYNC3_EN selects a 3-flop synchronizer (2 flops otherwise).
package tick_step_counter_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

`ifdef TICK_STEP_COUNTER_SYNC3_EN
   localparam int unsigned SYNC_STAGES = 3;
`else
   localparam int unsigned SYNC_STAGES = 2;
`endif

endpackage

// File: rtl/tick_step_counter_if.sv
// Control/status bundle of the step counter; the counter is the slave, its driver the master.
// Build option: TICK_STEP_COUNTER_SYNC3_EN (no effect on this interface).
interface tick_step_counter_if #(
   parameter int unsigned WIDTH = 8
) ();

   logic             slow_clk;
   logic             start;
   logic             stop;
   logic             oneshot;
   logic             up_down;
   logic             load;
   logic [WIDTH-1:0] load_value;
   logic [WIDTH-1:0] max_value;
   logic [WIDTH-1:0] count;
   logic             tick;
   logic             wrap;
   logic             done;
   logic             running;

   modport master (
      output slow_clk, start, stop, oneshot, up_down, load, load_value, max_value,
      input  count, tick, wrap, done, running
   );

   modport slave (
      input  slow_clk, start, stop, oneshot, up_down, load, load_value, max_value,
      output count, tick, wrap, done, running
   );

endinterface

// File: rtl/tick_step_counter_edge_sync.sv
// Synchronizes an asynchronous level into clockin and flags its rising edges.
// Build option: TICK_STEP_COUNTER_SYNC3_EN sets the default chain length through the package.
module edge_sync
   import tick_step_counter_pkg::*;
#(
   parameter int unsigned STAGES = SYNC_STAGES
) (
   input  logic clockin,
   input  logic reset_n,
   input  logic async_in,
   output logic rise
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   // Shift the async level through the chain; prev_q remembers the last synchronized sample.
   always_ff @(posedge clockin or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], async_in};
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign rise = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/tick_step_counter.sv
// Step counter advanced by rising edges of a slow divided clock sampled as data on clockin.
// Build option: TICK_STEP_COUNTER_SYNC3_EN adds one synchronizer stage (one more cycle latency).
module tick_step_counter
   import tick_step_counter_pkg::*;
#(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned INIT_COUNT = 0
) (
   input  logic            clockin,
   input  logic            reset_n,
   tick_step_counter_if.slave bus
);

   logic             rise;
   logic [WIDTH-1:0] clamped_load;
   logic [WIDTH-1:0] restart_value;
   logic             at_terminal;

   state_t           state_q;
   logic [WIDTH-1:0] count_q;
   logic             tick_q;
   logic             wrap_q;
   logic             done_q;
   logic             running_q;

   edge_sync #(
      .STAGES (SYNC_STAGES)
   ) u_edge_sync (
      .clockin  (clockin),
      .reset_n  (reset_n),
      .async_in (bus.slow_clk),
      .rise     (rise)
   );

   // Load clamp, direction-dependent restart value and terminal-count detect.
   always_comb begin
      clamped_load  = (bus.load_value > bus.max_value) ? bus.max_value : bus.load_value;
      restart_value = bus.up_down ? '0 : bus.max_value;
      // >= so a max_value lowered beneath count still terminates on the next rise
      at_terminal   = bus.up_down ? (count_q >= bus.max_value) : (count_q == '0);
   end

   // Control FSM and counter; priority is load > stop > start > rise.
   always_ff @(posedge clockin or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         count_q   <= WIDTH'(INIT_COUNT);
         tick_q    <= 1'b0;
         wrap_q    <= 1'b0;
         done_q    <= 1'b0;
         running_q <= 1'b0;
      end else begin
         tick_q <= rise;
         wrap_q <= 1'b0;
         done_q <= 1'b0;
         if (bus.load) begin
            count_q <= clamped_load;
         end else if (bus.stop) begin
            if (state_q == RUN) begin
               state_q   <= IDLE;
               running_q <= 1'b0;
            end
         end else if (bus.start && (state_q != RUN)) begin
            if (state_q == DONE) begin
               count_q <= restart_value;
            end
            state_q   <= RUN;
            running_q <= 1'b1;
         end else if ((state_q == RUN) && rise) begin
            if (!at_terminal) begin
               count_q <= bus.up_down ? count_q + 1'b1 : count_q - 1'b1;
            end else if (bus.oneshot) begin
               state_q   <= DONE;
               running_q <= 1'b0;
               done_q    <= 1'b1;
            end else begin
               count_q <= restart_value;
               wrap_q  <= 1'b1;
            end
         end
      end
   end

   assign bus.count   = count_q;
   assign bus.tick    = tick_q;
   assign bus.wrap    = wrap_q;
   assign bus.done    = done_q;
   assign bus.running = running_q;

endmodule

// File: tb/tb_tick_step_counter.sv
// Self-checking bench for tick_step_counter with a per-cycle behavioural reference model.
// Build option: TICK_STEP_COUNTER_SYNC3_EN changes the expected tick latency from 3 to 4.
module tb_tick_step_counter;

`ifdef TICK_STEP_COUNTER_SYNC3_EN
   localparam int LAT = 4;
`else
   localparam int LAT = 3;
`endif
   localparam int INIT = 0;

   logic clockin;
   logic reset_n;

   tick_step_counter_if #(.WIDTH(8)) bus ();

   tick_step_counter #(
      .WIDTH      (8),
      .INIT_COUNT (INIT)
   ) dut (
      .clockin (clockin),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial begin
      clockin = 1'b0;
      forever #5 clockin = ~clockin;
   end

   int checks = 0;
   int errors = 0;

   // Reference model: mode 0 idle, 1 run, 2 done.
   int m_mode, m_count, m_tick, m_wrap, m_done;
   int rise_q[$];   // clockin edge numbers at which a slow_clk rise is due to register
   int cur_edge = 0;
   bit slow_en = 0;
   int slow_cnt = 0;
   int tc[8];
   int wrap_seen, done_seen, wrap_at;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_count = INIT; m_tick = 0; m_wrap = 0; m_done = 0;
      rise_q.delete();
   endtask

   // Drive slow_clk; a 0->1 change is first sampled at the next edge and ticks LAT-1 edges later.
   task automatic set_slow(input logic v);
      if (v && !bus.slow_clk) rise_q.push_back(cur_edge + LAT);
      bus.slow_clk = v;
   endtask

   task automatic model_edge();
      int r, mv;
      r = 0;
      if (rise_q.size() > 0 && rise_q[0] == cur_edge) begin
         r = 1;
         void'(rise_q.pop_front());
      end
      mv = int'(bus.max_value);
      m_tick = r; m_wrap = 0; m_done = 0;
      if (bus.load) begin
         m_count = (int'(bus.load_value) < mv) ? int'(bus.load_value) : mv;
      end else if (bus.stop) begin
         if (m_mode == 1) m_mode = 0;
      end else if (bus.start && m_mode != 1) begin
         if (m_mode == 2) m_count = bus.up_down ? 0 : mv;
         m_mode = 1;
      end else if (m_mode == 1 && r == 1) begin
         if (bus.up_down) begin
            if (m_count < mv) m_count = m_count + 1;
            else if (bus.oneshot) begin m_mode = 2; m_done = 1; end
            else begin m_count = 0; m_wrap = 1; end
         end else begin
            if (m_count > 0) m_count = m_count - 1;
            else if (bus.oneshot) begin m_mode = 2; m_done = 1; end
            else begin m_count = mv; m_wrap = 1; end
         end
      end
   endtask

   task automatic cycle();
      @(posedge clockin);
      cur_edge++;
      model_edge();
      #1;
      chk("count", 32'(bus.count), 32'(m_count));
      chk("tick", 32'(bus.tick), 32'(m_tick));
      chk("wrap", 32'(bus.wrap), 32'(m_wrap));
      chk("done", 32'(bus.done), 32'(m_done));
      chk("running", 32'(bus.running), 32'(m_mode == 1));
      if (slow_en) begin
         slow_cnt--;
         if (slow_cnt <= 0) begin
            slow_cnt = int'($urandom_range(6, 2));
            set_slow(~bus.slow_clk);
         end
      end
   endtask

   task automatic run_ticks(input int n, input string tag);
      int got;
      got = 0; wrap_seen = 0; done_seen = 0; wrap_at = -1;
      for (int i = 0; i < 600 && got < n; i++) begin
         cycle();
         if (bus.wrap) begin wrap_seen++; wrap_at = got; end
         if (bus.done) done_seen++;
         if (m_tick == 1) begin
            if (got < 8) tc[got] = int'(bus.count);
            got++;
         end
      end
      chk(tag, 32'(got), 32'(n));
   endtask

   task automatic do_reset();
      bus.slow_clk = 1'b0;
      slow_en = 0;
      reset_n = 1'b0;
      #1;
      chk("rst_count", 32'(bus.count), 32'(INIT));
      chk("rst_tick", 32'(bus.tick), 32'd0);
      chk("rst_wrap", 32'(bus.wrap), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_running", 32'(bus.running), 32'd0);
      model_reset();
      @(posedge clockin);
      cur_edge++;
      @(negedge clockin);
      reset_n = 1'b1;
   endtask

   initial begin
      int found, saved;
      reset_n = 1'b1;
      bus.slow_clk = 1'b0; bus.start = 0; bus.stop = 0; bus.oneshot = 0; bus.up_down = 1;
      bus.load = 0; bus.load_value = '0; bus.max_value = 8'd3;
      #2;
      do_reset();

      // Latency: start held, then one rise of slow_clk.
      bus.start = 1;
      cycle();
      set_slow(1'b1);
      saved = cur_edge;
      for (int i = 0; i < 20 && !bus.tick; i++) cycle();
      chk("latency", 32'(cur_edge - saved), 32'(LAT));
      chk("first_count", 32'(bus.count), 32'd1);
      bus.start = 0;
      for (int i = 0; i < 8; i++) cycle();   // held high: no further ticks
      slow_cnt = 1;
      slow_en = 1;

      // Up wrap over max_value=3.
      run_ticks(4, "up_ticks");
      chk("up_seq0", 32'(tc[0]), 32'd2);
      chk("up_seq1", 32'(tc[1]), 32'd3);
      chk("up_seq2", 32'(tc[2]), 32'd0);
      chk("up_seq3", 32'(tc[3]), 32'd1);
      chk("up_wraps", 32'(wrap_seen), 32'd1);
      chk("up_wrap_at", 32'(wrap_at), 32'd2);

      // Down, one-shot from 2.
      bus.up_down = 0; bus.oneshot = 1; bus.load = 1; bus.load_value = 8'd2;
      cycle();
      bus.load = 0;
      chk("dn_load", 32'(bus.count), 32'd2);
      run_ticks(3, "dn_ticks");
      chk("dn_seq0", 32'(tc[0]), 32'd1);
      chk("dn_seq1", 32'(tc[1]), 32'd0);
      chk("dn_seq2", 32'(tc[2]), 32'd0);
      chk("dn_dones", 32'(done_seen), 32'd1);
      chk("dn_wraps", 32'(wrap_seen), 32'd0);
      chk("dn_idle_run", 32'(bus.running), 32'd0);
      bus.start = 1;
      cycle();
      bus.start = 0;
      chk("dn_restart", 32'(bus.count), 32'd3);
      chk("dn_restart_run", 32'(bus.running), 32'd1);

      // Clamped load, then load coincident with a rise.
      bus.max_value = 8'd59; bus.load = 1; bus.load_value = 8'd200;
      cycle();
      bus.load = 0;
      chk("clamp", 32'(bus.count), 32'd59);
      found = 0;
      for (int i = 0; i < 100; i++) begin
         if (rise_q.size() > 0 && rise_q[0] == cur_edge + 1) begin found = 1; break; end
         cycle();
      end
      chk("rise_wait", 32'(found), 32'd1);
      bus.load = 1;
      cycle();
      bus.load = 0;
      chk("load_rise_tick", 32'(bus.tick), 32'd1);
      chk("load_rise_count", 32'(bus.count), 32'd59);

      // stop and start together.
      bus.stop = 1; bus.start = 1;
      cycle();
      bus.stop = 0; bus.start = 0;
      chk("stop_wins", 32'(bus.running), 32'd0);
      saved = m_count;
      run_ticks(3, "idle_ticks");
      chk("idle_hold", 32'(bus.count), 32'(saved));

      // max_value lowered below count while running up.
      bus.start = 1;
      cycle();
      bus.start = 0; bus.up_down = 1; bus.oneshot = 0; bus.max_value = 8'd100;
      bus.load = 1; bus.load_value = 8'd50;
      cycle();
      bus.load = 0;
      chk("load50", 32'(bus.count), 32'd50);
      bus.max_value = 8'd10;
      run_ticks(1, "lower_tick");
      chk("lower_count", 32'(bus.count), 32'd0);
      chk("lower_wrap", 32'(bus.wrap), 32'd1);

      // Randomized control traffic.
      for (int i = 0; i < 1500; i++) begin
         bus.load = ($urandom_range(31) == 0);
         bus.load_value = 8'($urandom_range(255));
         bus.stop = ($urandom_range(40) == 0);
         bus.start = ($urandom_range(12) == 0);
         if ($urandom_range(20) == 0) bus.up_down = ~bus.up_down;
         if ($urandom_range(30) == 0) bus.oneshot = ~bus.oneshot;
         if ($urandom_range(40) == 0) bus.max_value = 8'($urandom_range(15));
         cycle();
      end

      // Asynchronous reset mid-run.
      bus.load = 0; bus.stop = 0; bus.start = 1; bus.max_value = 8'd9;
      cycle();
      bus.start = 0;
      cycle();
      chk("pre_rst_run", 32'(bus.running), 32'd1);
      #2;
      do_reset();
      for (int i = 0; i < 10; i++) cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
